// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   VGA raster timing generator. A clock divider produces the pixel enable
//   (pix_tick) and the DAC pixel clock (vga_clk). The horizontal and vertical
//   counters advance once per pixel and are presented as x/y to the pixel
//   generator. That block returns combinational r_in/g_in/b_in. Colour,
//   blanking and syncs are then registered together, so all DAC-side outputs
//   lag x/y by exactly one pixel tick and stay mutually aligned.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   x, y          [9:0]   current h/v count, held for CLK_DIV clocks
//   r_in,g_in,b_in [7:0]  colour for (x,y) from the pixel generator
//   r, g, b       [7:0]   registered colour, forced to 0 outside active video
//   hsync, vsync          registered syncs, active level HS_POL/VS_POL
//   blank_n               registered, 1 = visible pixel
//   vga_clk               pixel clock, high for the upper half of the divider
//   pix_tick              one-clock pixel enable
//   line_start            one-clock pulse on horizontal wrap
//   frame_start           one-clock pulse on frame wrap
//
// H_TOTAL and V_TOTAL must both be <= 1024 to fit the 10-bit counters.

module vga_timing_ctrl #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       vga_clk,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic [7:0]       r_r, r_g, r_b;
  logic             r_hsync, r_vsync, r_blank_n;

  logic w_tick;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;

  // Divider, tick and pixel clock
  assign w_tick  = (r_div_cnt == DIV_MAX);
  assign vga_clk = (r_div_cnt >= DIV_HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Raster counters, advanced only on the pixel enable
  assign w_h_wrap = (r_h_cnt == H_MAX);
  assign w_v_wrap = (r_v_cnt == V_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_tick) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        if (w_v_wrap) begin
          r_v_cnt <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + 10'd1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Decode of the current (unregistered) raster position
  assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_raw = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
  assign w_vs_raw = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

  // Output stage: colour is sampled together with the timing decode of the
  // same pixel, which gives the one-tick lag shared by every DAC output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_blank_n <= 1'b0;
      r_hsync   <= ~HS_POL;
      r_vsync   <= ~VS_POL;
    end else if (w_tick) begin
      r_r       <= w_active ? r_in : '0;
      r_g       <= w_active ? g_in : '0;
      r_b       <= w_active ? b_in : '0;
      r_blank_n <= w_active;
      r_hsync   <= w_hs_raw ? HS_POL : ~HS_POL;
      r_vsync   <= w_vs_raw ? VS_POL : ~VS_POL;
    end
  end

  assign x           = r_h_cnt;
  assign y           = r_v_cnt;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_n     = r_blank_n;
  assign pix_tick    = w_tick;
  assign line_start  = w_tick && w_h_wrap;
  assign frame_start = w_tick && w_h_wrap && w_v_wrap;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

  // Instance A: default horizontal timing, shortened vertical timing
  localparam int A_CD = 2;
  localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 6,   A_VF = 2,  A_VS = 2,  A_VB = 2;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;

  // Instance B: tiny raster with a divide-by-4 pixel clock
  localparam int B_CD = 4;
  localparam int B_HA = 4, B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int B_VA = 2, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

  localparam logic [26:0] RST_OUT = {24'h0, 1'b0, 1'b1, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [9:0] xa, ya, xb, yb;
  logic [7:0] ri_a, gi_a, bi_a, ra, ga, ba;
  logic [7:0] ri_b, gi_b, bi_b, rb, gb, bb;
  logic       hs_a, vs_a, bn_a, vclk_a, tick_a, ls_a, fs_a;
  logic       hs_b, vs_b, bn_b, vclk_b, tick_b, ls_b, fs_b;

  vga_timing_ctrl #(
    .CLK_DIV(A_CD), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .x(xa), .y(ya),
    .r_in(ri_a), .g_in(gi_a), .b_in(bi_a), .r(ra), .g(ga), .b(ba),
    .hsync(hs_a), .vsync(vs_a), .blank_n(bn_a), .vga_clk(vclk_a),
    .pix_tick(tick_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_ctrl #(
    .CLK_DIV(B_CD), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .x(xb), .y(yb),
    .r_in(ri_b), .g_in(gi_b), .b_in(bi_b), .r(rb), .g(gb), .b(bb),
    .hsync(hs_b), .vsync(vs_b), .blank_n(bn_b), .vga_clk(vclk_b),
    .pix_tick(tick_b), .line_start(ls_b), .frame_start(fs_b)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [23:0] pat(input int h, input int v);
    return {8'(h), 8'(v), 8'(h ^ v) + 8'd1};
  endfunction

  // Expected {r,g,b,blank_n,hsync,vsync} one tick after pixel (h,v) is sampled
  function automatic logic [26:0] exp_out(input int ha, input int hf, input int hsw,
                                          input int va, input int vf, input int vsw,
                                          input int h, input int v, input logic [23:0] px);
    logic act, hsr, vsr;
    act = (h < ha) && (v < va);
    hsr = (h >= ha + hf) && (h < ha + hf + hsw);
    vsr = (v >= va + vf) && (v < va + vf + vsw);
    return {act ? px : 24'h0, act, ~hsr, ~vsr};
  endfunction

  // Clock edges seen since the last reset release, per instance
  int unsigned c_a, c_b;
  always @(posedge clk or negedge rst_n_a)
    if (!rst_n_a) c_a <= 0; else c_a <= c_a + 1;
  always @(posedge clk or negedge rst_n_b)
    if (!rst_n_b) c_b <= 0; else c_b <= c_b + 1;

  logic [26:0] q_a[$];
  logic [26:0] q_b[$];
  logic [26:0] last_a, last_b;
  int unsigned fprev_a, fprev_b;
  bit          fseen_a, fseen_b;
  int          lines_a, lines_b;

  always @(negedge clk) begin : sb_a
    int d, p, h, v;
    logic [23:0] px;
    if (!rst_n_a) begin
      q_a.delete();
      last_a  = RST_OUT;
      fseen_a = 1'b0;
      lines_a = 0;
      {ri_a, gi_a, bi_a} = 24'h0;
    end else begin
      d = int'(c_a % A_CD);
      p = int'(c_a / A_CD);
      h = p % A_HT;
      v = (p / A_HT) % A_VT;
      if (d == 0 && c_a >= A_CD) begin
        check("a_sb_depth", q_a.size(), 1);
        if (q_a.size() != 0) last_a = q_a.pop_front();
      end
      check("a_x", xa, h);
      check("a_y", ya, v);
      check("a_tick", tick_a, d == A_CD - 1);
      check("a_vga_clk", vclk_a, d >= A_CD / 2);
      check("a_line_start", ls_a, (d == A_CD - 1) && (h == A_HT - 1));
      check("a_frame_start", fs_a, (d == A_CD - 1) && (h == A_HT - 1) && (v == A_VT - 1));
      check("a_out", {ra, ga, ba, bn_a, hs_a, vs_a}, last_a);
      if (ls_a) lines_a++;
      if (fs_a) begin
        if (fseen_a) check("a_frame_period", c_a - fprev_a, A_CD * A_HT * A_VT);
        else         check("a_first_frame", c_a, A_CD * A_HT * A_VT - 1);
        check("a_lines_per_frame", lines_a, A_VT);
        lines_a = 0;
        fprev_a = c_a;
        fseen_a = 1'b1;
      end
      if (d == A_CD - 1) begin
        px = pat(h, v);
        {ri_a, gi_a, bi_a} = px;
        q_a.push_back(exp_out(A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, h, v, px));
      end else begin
        {ri_a, gi_a, bi_a} = 24'($urandom);
      end
    end
  end

  always @(negedge clk) begin : sb_b
    int d, p, h, v;
    logic [23:0] px;
    if (!rst_n_b) begin
      q_b.delete();
      last_b  = RST_OUT;
      fseen_b = 1'b0;
      lines_b = 0;
      {ri_b, gi_b, bi_b} = 24'h0;
    end else begin
      d = int'(c_b % B_CD);
      p = int'(c_b / B_CD);
      h = p % B_HT;
      v = (p / B_HT) % B_VT;
      if (d == 0 && c_b >= B_CD) begin
        check("b_sb_depth", q_b.size(), 1);
        if (q_b.size() != 0) last_b = q_b.pop_front();
      end
      check("b_x", xb, h);
      check("b_y", yb, v);
      check("b_tick", tick_b, d == B_CD - 1);
      check("b_vga_clk", vclk_b, d >= B_CD / 2);
      check("b_line_start", ls_b, (d == B_CD - 1) && (h == B_HT - 1));
      check("b_frame_start", fs_b, (d == B_CD - 1) && (h == B_HT - 1) && (v == B_VT - 1));
      check("b_out", {rb, gb, bb, bn_b, hs_b, vs_b}, last_b);
      if (ls_b) lines_b++;
      if (fs_b) begin
        if (fseen_b) check("b_frame_period", c_b - fprev_b, B_CD * B_HT * B_VT);
        else         check("b_first_frame", c_b, B_CD * B_HT * B_VT - 1);
        check("b_lines_per_frame", lines_b, B_VT);
        lines_b = 0;
        fprev_b = c_b;
        fseen_b = 1'b1;
      end
      if (d == B_CD - 1) begin
        px = pat(h, v);
        {ri_b, gi_b, bi_b} = px;
        q_b.push_back(exp_out(B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, h, v, px));
      end else begin
        {ri_b, gi_b, bi_b} = 24'($urandom);
      end
    end
  end

  task automatic check_reset_a(input string tag);
    check({tag, "_x"}, xa, 0);
    check({tag, "_y"}, ya, 0);
    check({tag, "_out"}, {ra, ga, ba, bn_a, hs_a, vs_a}, RST_OUT);
    check({tag, "_vga_clk"}, vclk_a, 0);
    check({tag, "_pulses"}, {tick_a, ls_a, fs_a}, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin : stim
    bit found;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("rst");
    check("rst_b_out", {rb, gb, bb, bn_b, hs_b, vs_b}, RST_OUT);
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Two full frames of instance A (instance B wraps many times meanwhile)
    repeat (2 * A_CD * A_HT * A_VT + 50) @(negedge clk);

    // Reach x=300, y=3 of instance A, then reset it mid-line
    found = 1'b0;
    for (int i = 0; i < A_CD * A_HT * A_VT + 10; i++) begin
      @(negedge clk);
      if (((c_a / A_CD) % A_HT) == 300 && ((c_a / (A_CD * A_HT)) % A_VT) == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("midreset_reached", found, 1'b1);
    #2;
    rst_n_a = 1'b0;
    #1;
    check_reset_a("midrst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("midrst_hold");
    @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    check("rel_first_tick", tick_a, 1'b1);
    check("rel_x0", xa, 0);
    @(negedge clk);
    check("rel_x1", xa, 1);
    check("rel_y0", ya, 0);

    repeat (4 * A_CD * A_HT) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
